msx_mouse_reader: RTL
=====================

Name: msx_mouse_reader

Overview:
- Host-side reader for the MSX mouse joystick-port protocol.
- Drives the port strobe (pin 8), toggling once per nibble, and samples four 4-bit nibbles in the order X-high, X-low, Y-high, Y-low.
- Assembles signed 8-bit dx/dy and button state, and reports each completed frame with a one-cycle valid pulse.
- Sits between a physical MSX joystick port and host logic (an OSD/HID bridge or the PS/2-mouse merge path), in the clk_sys domain.

Parameters:
- SETTLE_CYC, 2148, clocks from a strobe toggle to the nibble sample (~100 us at 21.48 MHz); minimum 4.
- IDLE_CYC, 120000, minimum strobe-quiet gap between frames. Must exceed the responder's nibble-index timeout (100000) so the mouse resyncs to nibble 0.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  1 = poll continuously; 0 = finish the current frame, then stay idle
- joy_i  in  6  raw port pins, asynchronous: [3:0] nibble (bit0 = LSB), [5:4] buttons right/left, active-low
- strobe_o  out  1  port strobe (pin 8)
- dx  out  8  X displacement, two's complement, as delivered
- dy  out  8  Y displacement, two's complement, as delivered
- buttons  out  2  [1] right, [0] left, active-high
- valid  out  1  one-cycle pulse: dx/dy/buttons updated
- busy  out  1  1 while a frame is in progress

Behaviour:
- Reset (async assert, sync-released internally):
  - strobe_o=0, dx=0, dy=0, buttons=0, valid=0, busy=0.
  - State IDLE; gap counter loaded with IDLE_CYC; nibble index 0; synchronizer flops cleared to all-ones (idle port).
- Input sync: joy_i passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- FSM states: IDLE, TOGGLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - Gap counter decrements every cycle to 0 and holds there.
  - When gap==0 and enable==1: go to TOGGLE, index=0, busy=1.
  - When enable==0: remain in IDLE with the counter at 0.
- TOGGLE (1 cycle): strobe_o <= ~strobe_o; settle counter <= SETTLE_CYC-1; go to SETTLE.
- SETTLE: decrement the counter; at 0, go to SAMPLE.
- SAMPLE (1 cycle): latch the synchronized nibble into shadow register[index].
  - index 3: also latch buttons = ~sync[5:4]; go to DONE.
  - Otherwise: index+1, go to TOGGLE.
- DONE (1 cycle):
  - dx <= {n0,n1}, dy <= {n2,n3}, buttons updated.
  - valid=1 this cycle only; busy=0.
  - Reload gap counter with IDLE_CYC; go to IDLE.
- Timing:
  - One nibble phase = SETTLE_CYC+2 cycles. One frame = 4*(SETTLE_CYC+2)+1 cycles from the first toggle to valid.
  - Minimum toggle-to-toggle distance of the next frame = IDLE_CYC+1.
- Strobe polarity: level-insensitive. Frame boundaries are established only by the idle gap, never by strobe level; strobe_o keeps its last level across frames.
- dx/dy/buttons update atomically, only in DONE. Partial frames are never exposed.
- enable deasserted mid-frame: the frame completes and valid pulses; no further frame starts.
- Async reset mid-frame:
  - Abort immediately; shadow registers are discarded; outputs take reset values.
  - The first post-reset frame starts no earlier than IDLE_CYC cycles after release, which guarantees responder resync.
- No mouse connected: the port reads all-ones, giving dx=dy=8'hFF and buttons=0. No presence detection in this block.

Test Plan (sim with SETTLE_CYC=4, IDLE_CYC=20, responder model with toggle-driven nibble index and 16-cycle timeout):
- Reset released, enable=1, responder dx=8'h05, dy=8'hFB, left pressed:
  - First toggle at cycle 20 after release.
  - valid at 4*6+1=25 cycles after the first toggle, with dx=05, dy=FB, buttons=2'b01.
  - Exactly 4 strobe edges observed.
- Back-to-back frames with values changing to dx=8'h80, dy=8'h7F:
  - Second frame starts 21 cycles after the first valid.
  - Strobe continues from its last level.
  - valid reports 80/7F.
  - dx/dy stable between valid pulses.
- enable dropped during nibble 2:
  - The frame completes and valid pulses once.
  - No strobe activity for 200 further cycles; busy=0.
- reset_n asserted during SETTLE of nibble 1:
  - Outputs go to 0 immediately, strobe_o=0, no valid.
  - After release, a full frame decodes correctly: the responder has timed out to index 0.
- Port idle (joy_i=6'h3F): valid with dx=FF, dy=FF, buttons=00.
- Input change exactly at the sample cycle: the value captured is the one present 2 cycles earlier (synchronizer latency check). No X/metastability propagates to dx.

Source files
------------

// File: rtl/msx_mouse_reader.sv
// MSX mouse reader: drives the joystick-port strobe, samples four nibbles
// per frame (X-high, X-low, Y-high, Y-low) and reports signed dx/dy plus
// button state with a one-cycle valid pulse. Runs entirely in clk_sys.
module msx_mouse_reader #(
  parameter int SETTLE_CYC = 2148,   // strobe toggle to nibble sample, >= 4
  parameter int IDLE_CYC   = 120000  // strobe-quiet gap between frames
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [5:0] joy_i,
  output logic       strobe_o,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic [1:0] buttons,
  output logic       valid,
  output logic       busy
);

  localparam int GAP_W    = $clog2(IDLE_CYC + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYC);

  typedef enum logic [2:0] {
    IDLE,
    TOGGLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          rst_sync;
  logic                rst_n;
  logic [5:0]          joy_meta, joy_sync;
  logic [GAP_W-1:0]    gap_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [1:0]          idx_q;
  logic [3:0]          shadow [4];
  logic [1:0]          btn_shadow;

  // Reset synchronizer: assert asynchronously, release on clk_sys.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Two-flop synchronizer on the asynchronous port pins; idle port reads all-ones.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, making the two stages a real pipeline.
    if (!rst_n) begin
      joy_meta <= 6'h3F;
      joy_sync <= 6'h3F;
    end else begin
      joy_meta <= joy_i;
      joy_sync <= joy_meta;
    end
  end

  // State register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: frame sequencing through four nibble phases.
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // state_d unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (gap_q == '0 && enable) state_d = TOGGLE;
      TOGGLE:  state_d = SETTLE;
      SETTLE:  if (settle_q == '0) state_d = SAMPLE;
      SAMPLE:  state_d = (idx_q == 2'd3) ? DONE : TOGGLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: counters, strobe, nibble capture and atomic output update.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      gap_q      <= GAP_W'(IDLE_CYC);
      settle_q   <= '0;
      idx_q      <= 2'd0;
      strobe_o   <= 1'b0;
      dx         <= 8'h00;
      dy         <= 8'h00;
      buttons    <= 2'b00;
      valid      <= 1'b0;
      busy       <= 1'b0;
      btn_shadow <= 2'b00;
      // NOTE: the shadow nibbles are only four small flops, so they are
      // reset explicitly; an aborted frame then leaves nothing stale behind.
      for (int i = 0; i < 4; i++) shadow[i] <= 4'h0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gap_q != '0) gap_q <= gap_q - GAP_W'(1);
          if (state_d == TOGGLE) begin
            idx_q <= 2'd0;
            busy  <= 1'b1;
          end
        end
        TOGGLE: begin
          strobe_o <= ~strobe_o;
          settle_q <= SETTLE_W'(SETTLE_CYC - 1);
        end
        SETTLE: begin
          if (settle_q != '0) settle_q <= settle_q - SETTLE_W'(1);
        end
        SAMPLE: begin
          shadow[idx_q] <= joy_sync[3:0];
          if (idx_q == 2'd3) btn_shadow <= ~joy_sync[5:4];
          else               idx_q      <= idx_q + 2'd1;
        end
        DONE: begin
          dx      <= {shadow[0], shadow[1]};
          dy      <= {shadow[2], shadow[3]};
          buttons <= btn_shadow;
          valid   <= 1'b1;
          busy    <= 1'b0;
          gap_q   <= GAP_W'(IDLE_CYC);
        end
        default: ;
      endcase
    end
  end

endmodule
